systolic_seq_ctrl: RTL

//  Sequencer for the N-tap systolic filter wrapper (xin/yout/donext).
//  - Buffers incoming samples in a small FIFO.
//  - Issues one-cycle donext strobes spaced PERIOD clocks apart and drives xin.
//  - Captures yout at each strobe and returns filter results on a valid/ready stream.
//  - Replaces the hand-timed donext pacing used in the array benches.

---
 rtl/systolic_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: FIFO-buffered, PERIOD-paced donext sequencer for the systolic filter array.
// Define SEQ_FLUSH_EN to add flush/flush_done drain support.
module systolic_seq_ctrl #(
   parameter int W          = 16,
   parameter int PERIOD     = 30,
   parameter int FIFO_DEPTH = 4,
   parameter int PIPE_LAT   = 2,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(PERIOD),
   localparam int PW = $clog2(PIPE_LAT + 1)
) (
   input  logic         clk30x,
   input  logic         rst,
`ifdef SEQ_FLUSH_EN
   input  logic         flush,
   output logic         flush_done,
`endif
   input  logic         en,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic [W-1:0] xin,
   output logic         donext,
   input  logic [W-1:0] yout,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data,
   output logic [AW:0]  fifo_level
);
   typedef enum logic {S_WAIT, S_STROBE} state_t;
   state_t state_q, state_d;
   logic [W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wr_q, rd_q;
   logic [CW-1:0] pcnt_q, pcnt_d;
   logic [PW-1:0] prime_q, prime_d;
   logic [W-1:0] xin_q, xin_d, m_data_q, m_data_d;
   logic m_valid_q, m_valid_d;
   logic push, empty, elig, go_real, go_drain, hold_real, cap, last_drain;

   assign fifo_level = wr_q - rd_q;
   assign empty = fifo_level == '0;
   assign s_ready = fifo_level != (AW+1)'(FIFO_DEPTH);
   assign push = s_valid && s_ready;
   assign donext = state_q == S_STROBE;
   assign xin = xin_q;
   assign m_valid = m_valid_q;
   assign m_data = m_data_q;
   // The output slot must be free (or freeing this edge) before a strobe, so a capture never overwrites.
   assign elig = state_q == S_WAIT && pcnt_q == CW'(PERIOD - 1) && en && (!m_valid_q || m_ready);
   assign go_real = elig && !empty && !hold_real;
   assign cap = state_q == S_STROBE && prime_q == PW'(PIPE_LAT);

`ifdef SEQ_FLUSH_EN
   logic drain_q, done_q;
   logic [PW-1:0] dcnt_q;
   assign hold_real = dcnt_q != '0;
   assign go_drain = elig && drain_q && (empty || hold_real) && dcnt_q != PW'(PIPE_LAT);
   assign last_drain = state_q == S_STROBE && dcnt_q == PW'(PIPE_LAT);
   assign flush_done = done_q;
   always_ff @(posedge clk30x or posedge rst) begin
      if (rst) begin
         drain_q <= 1'b0;
         done_q <= 1'b0;
         dcnt_q <= '0;
      end else begin
         drain_q <= last_drain ? 1'b0 : drain_q || flush;
         done_q <= last_drain;
         dcnt_q <= last_drain ? '0 : go_drain ? dcnt_q + PW'(1) : dcnt_q;
      end
   end
`else
   assign hold_real = 1'b0;
   assign go_drain = 1'b0;
   assign last_drain = 1'b0;
`endif

   always_comb begin
      state_d = (go_real || go_drain) ? S_STROBE : S_WAIT;
      pcnt_d = (go_real || go_drain) ? '0 : (pcnt_q == CW'(PERIOD - 1)) ? pcnt_q : pcnt_q + CW'(1);
      xin_d = go_real ? mem_q[rd_q[AW-1:0]] : go_drain ? '0 : xin_q;
      prime_d = last_drain ? '0 : (state_q == S_STROBE && !cap) ? prime_q + PW'(1) : prime_q;
      m_valid_d = cap || (m_valid_q && !m_ready);
      m_data_d = cap ? yout : m_data_q;
   end

   always_ff @(posedge clk30x or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT;
         pcnt_q <= CW'(PERIOD - 1);
         prime_q <= '0;
         xin_q <= '0;
         m_valid_q <= 1'b0;
         m_data_q <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         state_q <= state_d;
         pcnt_q <= pcnt_d;
         prime_q <= prime_d;
         xin_q <= xin_d;
         m_valid_q <= m_valid_d;
         m_data_q <= m_data_d;
         wr_q <= push ? wr_q + (AW+1)'(1) : wr_q;
         rd_q <= go_real ? rd_q + (AW+1)'(1) : rd_q;
      end
   end

   always_ff @(posedge clk30x) begin
      if (push) mem_q[wr_q[AW-1:0]] <= s_data;
   end
endmodule
